// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and its helpers.
// Purpose: RV64 opcode constants, the hard-wired zero register address,
//          bus typedefs and the sequencer state enum.
// Ports:   none (package).
package pipe_hazard_ctrl_pkg;

   typedef logic [4:0]  RegAddrBus;
   typedef logic [63:0] AddrBus;
   typedef logic [6:0]  OpcodeBus;

   localparam OpcodeBus OPC_LOAD   = 7'b0000011;
   localparam OpcodeBus OPC_OP     = 7'b0110011;
   localparam OpcodeBus OPC_OP32   = 7'b0111011;
   localparam OpcodeBus OPC_STORE  = 7'b0100011;
   localparam OpcodeBus OPC_BRANCH = 7'b1100011;
   localparam OpcodeBus OPC_LUI    = 7'b0110111;
   localparam OpcodeBus OPC_AUIPC  = 7'b0010111;
   localparam OpcodeBus OPC_JAL    = 7'b1101111;
   localparam OpcodeBus OPC_JALR   = 7'b1100111;

   localparam RegAddrBus REG_ZERO = 5'd0;

   // RUN is normal flow; SHADOW keeps IF/ID flushed while the stale
   // fetches issued before a redirect drain out of the IRAM.
   typedef enum logic {
      ST_RUN,
      ST_SHADOW
   } HazState;

endpackage

// File: rtl/rs_use_decode.sv
// Register-usage decode.
// Purpose: tells whether the instruction with the given opcode actually
//          reads rs1 / rs2, so that spurious field matches do not cause
//          stalls or forwarding.
// Ports:   i_opcode   - opcode of the decoded instruction
//          o_rs1Used  - instruction reads rs1
//          o_rs2Used  - instruction reads rs2
module rs_use_decode
   import pipe_hazard_ctrl_pkg::*;
(
   input  OpcodeBus i_opcode,
   output logic     o_rs1Used,
   output logic     o_rs2Used
);

   // Only U-type and JAL lack rs1; only R, S and B formats carry rs2.
   always_comb begin
      o_rs1Used = 1'b1;
      o_rs2Used = 1'b0;
      case (i_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL:              o_rs1Used = 1'b0;
         OPC_OP, OPC_OP32, OPC_STORE, OPC_BRANCH:  o_rs2Used = 1'b1;
         OPC_LOAD, OPC_JALR:                       ;
         default:                                  ;
      endcase
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// Purpose: inserts the load-use stall bubble, sequences the flush after an
//          EX redirect (plus SHADOW_CYCLES of fetch-latency shadow), freezes
//          the pipe while data memory is busy and counts hazard events.
// Ports:   clk, rst                    - clock, synchronous active-high reset
//          id_opcode_i/rs1/rs2         - instruction currently in ID
//          ex_opcode_i/rd/wreg         - instruction currently in EX
//          ex_redirect_i/_pc_i         - taken branch/jump and its target
//          mem_busy_i                  - data memory stall request
//          pc_*, if_id_*, id_ex_*,
//          ex_mem_stall_o, mem_wb_bubble_o - per-register hold/bubble controls
//          loaduse_cnt_o, redirect_cnt_o   - performance counters
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int SHADOW_CYCLES = 1,
   parameter int CNT_W         = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  OpcodeBus         id_opcode_i,
   input  RegAddrBus        id_rs1_addr_i,
   input  RegAddrBus        id_rs2_addr_i,
   input  OpcodeBus         ex_opcode_i,
   input  RegAddrBus        ex_rd_addr_i,
   input  logic             ex_wreg_i,
   input  logic             ex_redirect_i,
   input  AddrBus           ex_redirect_pc_i,
   input  logic             mem_busy_i,
   output logic             pc_stall_o,
   output logic             pc_redirect_o,
   output AddrBus           pc_redirect_addr_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_stall_o,
   output logic             id_ex_bubble_o,
   output logic             ex_mem_stall_o,
   output logic             mem_wb_bubble_o,
   output logic [CNT_W-1:0] loaduse_cnt_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);

   localparam logic [1:0]       SH_LOAD = 2'(SHADOW_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   HazState          r_state;
   logic [1:0]       r_shCnt;
   logic [CNT_W-1:0] r_luCnt;
   logic [CNT_W-1:0] r_rdCnt;

   logic w_rs1Used;
   logic w_rs2Used;
   logic w_loadUse;
   logic w_evRedirect;
   logic w_evShadow;
   logic w_evLoadUse;

   rs_use_decode u_rsUse (
      .i_opcode  (id_opcode_i),
      .o_rs1Used (w_rs1Used),
      .o_rs2Used (w_rs2Used)
   );

   // A load in EX whose destination feeds the ID instruction cannot be
   // forwarded in time; x0 never carries a real dependency.
   assign w_loadUse = (ex_opcode_i == OPC_LOAD) && ex_wreg_i &&
                      (ex_rd_addr_i != REG_ZERO) &&
                      ((w_rs1Used && (id_rs1_addr_i == ex_rd_addr_i)) ||
                       (w_rs2Used && (id_rs2_addr_i == ex_rd_addr_i)));

   // Priority chain: reset, memory freeze, redirect, shadow flush, load-use.
   // The mem-busy freeze holds EX, so a pending redirect is simply replayed
   // once the freeze lifts. The ev* flags tell the state register which
   // event actually took effect this cycle.
   always_comb begin
      pc_stall_o      = 1'b0;
      pc_redirect_o   = 1'b0;
      if_id_stall_o   = 1'b0;
      if_id_flush_o   = 1'b0;
      id_ex_stall_o   = 1'b0;
      id_ex_bubble_o  = 1'b0;
      ex_mem_stall_o  = 1'b0;
      mem_wb_bubble_o = 1'b0;
      w_evRedirect    = 1'b0;
      w_evShadow      = 1'b0;
      w_evLoadUse     = 1'b0;
      if (rst) begin
         if_id_flush_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
      end else if (mem_busy_i) begin
         pc_stall_o      = 1'b1;
         if_id_stall_o   = 1'b1;
         id_ex_stall_o   = 1'b1;
         ex_mem_stall_o  = 1'b1;
         mem_wb_bubble_o = 1'b1;
      end else if (ex_redirect_i) begin
         pc_redirect_o  = 1'b1;
         if_id_flush_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
         w_evRedirect   = 1'b1;
      end else if (r_state == ST_SHADOW) begin
         if_id_flush_o = 1'b1;
         w_evShadow    = 1'b1;
      end else if (w_loadUse) begin
         pc_stall_o     = 1'b1;
         if_id_stall_o  = 1'b1;
         id_ex_bubble_o = 1'b1;
         w_evLoadUse    = 1'b1;
      end
   end

   assign pc_redirect_addr_o = ex_redirect_pc_i;
   assign loaduse_cnt_o      = rst ? '0 : r_luCnt;
   assign redirect_cnt_o     = rst ? '0 : r_rdCnt;

   // Sequencer state and counters. A redirect (re)loads the shadow count;
   // SHADOW leaves once the last shadow cycle has been flushed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_RUN;
         r_shCnt <= 2'd0;
         r_luCnt <= '0;
         r_rdCnt <= '0;
      end else if (w_evRedirect) begin
         r_rdCnt <= r_rdCnt + CNT_ONE;
         if (SHADOW_CYCLES > 0) begin
            r_state <= ST_SHADOW;
            r_shCnt <= SH_LOAD;
         end
      end else if (w_evShadow) begin
         if (r_shCnt <= 2'd1) begin
            r_state <= ST_RUN;
            r_shCnt <= 2'd0;
         end else begin
            r_shCnt <= r_shCnt - 2'd1;
         end
      end else if (w_evLoadUse) begin
         r_luCnt <= r_luCnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl.
// Two instances share the stimulus: A uses the default parameters, B uses
// SHADOW_CYCLES=2 and 4-bit counters so that wrap-around is reachable.
// A behavioural model (remaining-shadow-cycle count plus event counters)
// predicts every control output on each falling edge.
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_R32    = 7'b0111011;
   localparam logic [6:0] OP_S      = 7'b0100011;
   localparam logic [6:0] OP_B      = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_IMM    = 7'b0010011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  idOp = 7'd0;
   logic [4:0]  idRs1 = 5'd0;
   logic [4:0]  idRs2 = 5'd0;
   logic [6:0]  exOp = 7'd0;
   logic [4:0]  exRd = 5'd0;
   logic        exWreg = 1'b0;
   logic        exRedirect = 1'b0;
   logic [63:0] exPc = 64'd0;
   logic        memBusy = 1'b0;

   logic        aPcStall, aPcRedir, aIfIdStall, aIfIdFlush;
   logic        aIdExStall, aIdExBubble, aExMemStall, aMemWbBubble;
   logic [63:0] aAddr;
   logic [31:0] aLuCnt, aRdCnt;
   logic        bPcStall, bPcRedir, bIfIdStall, bIfIdFlush;
   logic        bIdExStall, bIdExBubble, bExMemStall, bMemWbBubble;
   logic [63:0] bAddr;
   logic [3:0]  bLuCnt, bRdCnt;

   int vectors = 0;
   int miscompares = 0;

   // Model state per instance: remaining shadow cycles and event counts.
   int     mSh  [2] = '{0, 0};
   longint mLu  [2] = '{0, 0};
   longint mRd  [2] = '{0, 0};
   int     shN  [2] = '{1, 2};
   longint cMod [2] = '{64'd4294967296, 64'd16};

   logic [6:0] idOps [10];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.SHADOW_CYCLES(1), .CNT_W(32)) dutA (
      .clk(clk), .rst(rst),
      .id_opcode_i(idOp), .id_rs1_addr_i(idRs1), .id_rs2_addr_i(idRs2),
      .ex_opcode_i(exOp), .ex_rd_addr_i(exRd), .ex_wreg_i(exWreg),
      .ex_redirect_i(exRedirect), .ex_redirect_pc_i(exPc), .mem_busy_i(memBusy),
      .pc_stall_o(aPcStall), .pc_redirect_o(aPcRedir), .pc_redirect_addr_o(aAddr),
      .if_id_stall_o(aIfIdStall), .if_id_flush_o(aIfIdFlush),
      .id_ex_stall_o(aIdExStall), .id_ex_bubble_o(aIdExBubble),
      .ex_mem_stall_o(aExMemStall), .mem_wb_bubble_o(aMemWbBubble),
      .loaduse_cnt_o(aLuCnt), .redirect_cnt_o(aRdCnt)
   );

   pipe_hazard_ctrl #(.SHADOW_CYCLES(2), .CNT_W(4)) dutB (
      .clk(clk), .rst(rst),
      .id_opcode_i(idOp), .id_rs1_addr_i(idRs1), .id_rs2_addr_i(idRs2),
      .ex_opcode_i(exOp), .ex_rd_addr_i(exRd), .ex_wreg_i(exWreg),
      .ex_redirect_i(exRedirect), .ex_redirect_pc_i(exPc), .mem_busy_i(memBusy),
      .pc_stall_o(bPcStall), .pc_redirect_o(bPcRedir), .pc_redirect_addr_o(bAddr),
      .if_id_stall_o(bIfIdStall), .if_id_flush_o(bIfIdFlush),
      .id_ex_stall_o(bIdExStall), .id_ex_bubble_o(bIdExBubble),
      .ex_mem_stall_o(bExMemStall), .mem_wb_bubble_o(bMemWbBubble),
      .loaduse_cnt_o(bLuCnt), .redirect_cnt_o(bRdCnt)
   );

   // Control bits packed as {pcStall, pcRedirect, ifIdStall, ifIdFlush,
   // idExStall, idExBubble, exMemStall, memWbBubble}.
   wire [7:0] aCtl = {aPcStall, aPcRedir, aIfIdStall, aIfIdFlush,
                      aIdExStall, aIdExBubble, aExMemStall, aMemWbBubble};
   wire [7:0] bCtl = {bPcStall, bPcRedir, bIfIdStall, bIfIdFlush,
                      bIdExStall, bIdExBubble, bExMemStall, bMemWbBubble};

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Expected outputs for instance k from the current inputs; advances the
   // model to the state it will hold after the coming rising edge.
   task automatic modelCycle(input int k, output logic [7:0] ctl,
                             output logic [31:0] luShown, output logic [31:0] rdShown);
      logic rs1U, rs2U, lu;
      rs1U = !(idOp == OP_LUI || idOp == OP_AUIPC || idOp == OP_JAL);
      rs2U = (idOp == OP_R || idOp == OP_R32 || idOp == OP_S || idOp == OP_B);
      lu = (exOp == OP_LOAD) && exWreg && (exRd != 5'd0) &&
           ((rs1U && idRs1 == exRd) || (rs2U && idRs2 == exRd));
      ctl = 8'b0000_0000;
      luShown = 32'(mLu[k]);
      rdShown = 32'(mRd[k]);
      if (rst) begin
         ctl = 8'b0001_0100;
         luShown = 32'd0;
         rdShown = 32'd0;
         mSh[k] = 0;
         mLu[k] = 0;
         mRd[k] = 0;
      end else if (memBusy) begin
         ctl = 8'b1010_1011;
      end else if (exRedirect) begin
         ctl = 8'b0101_0100;
         mRd[k] = (mRd[k] + 1) % cMod[k];
         mSh[k] = shN[k];
      end else if (mSh[k] > 0) begin
         ctl = 8'b0001_0000;
         mSh[k] = mSh[k] - 1;
      end else if (lu) begin
         ctl = 8'b1010_0100;
         mLu[k] = (mLu[k] + 1) % cMod[k];
      end
   endtask

   // Compare process: every falling edge, both instances against the model.
   always @(negedge clk) begin
      logic [7:0]  eCtl;
      logic [31:0] eLu, eRd;
      modelCycle(0, eCtl, eLu, eRd);
      checkOutput("A.ctl", {56'd0, aCtl}, {56'd0, eCtl});
      checkOutput("A.loaduse_cnt", {32'd0, aLuCnt}, {32'd0, eLu});
      checkOutput("A.redirect_cnt", {32'd0, aRdCnt}, {32'd0, eRd});
      if (eCtl[6]) checkOutput("A.redirect_addr", aAddr, exPc);
      modelCycle(1, eCtl, eLu, eRd);
      checkOutput("B.ctl", {56'd0, bCtl}, {56'd0, eCtl});
      checkOutput("B.loaduse_cnt", {60'd0, bLuCnt}, {32'd0, eLu});
      checkOutput("B.redirect_cnt", {60'd0, bRdCnt}, {32'd0, eRd});
      if (eCtl[6]) checkOutput("B.redirect_addr", bAddr, exPc);
   end

   task automatic applyStimulus(input logic r, input logic busy, input logic redir,
                                input logic [63:0] pc, input logic [6:0] eop,
                                input logic [4:0] rd, input logic wr,
                                input logic [6:0] iop, input logic [4:0] s1,
                                input logic [4:0] s2);
      @(posedge clk);
      #1;
      rst = r; memBusy = busy; exRedirect = redir; exPc = pc;
      exOp = eop; exRd = rd; exWreg = wr; idOp = iop; idRs1 = s1; idRs2 = s2;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, OP_IMM, 5'd0, 1'b0, OP_IMM, 5'd0, 5'd0);
      end
   endtask

   initial begin
      idOps = '{OP_LOAD, OP_R, OP_R32, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM};

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, OP_IMM, 5'd0, 1'b0, OP_IMM, 5'd0, 5'd0);
      settle();
      checkOutput("lit.reset_ctl", {56'd0, aCtl}, 64'h14);
      checkOutput("lit.reset_lucnt", {32'd0, aLuCnt}, 64'd0);
      idle(1);
      settle();
      checkOutput("lit.run_ctl", {56'd0, aCtl}, 64'h00);

      // Load-use: EX ld x5, ID add x6,x5,x1
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, OP_LOAD, 5'd5, 1'b1, OP_R, 5'd5, 5'd1);
      settle();
      checkOutput("lit.lu_ctl", {56'd0, aCtl}, 64'hA4);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, OP_IMM, 5'd0, 1'b0, OP_R, 5'd5, 5'd1);
      settle();
      checkOutput("lit.lu_after_ctl", {56'd0, aCtl}, 64'h00);
      checkOutput("lit.lu_cnt1", {32'd0, aLuCnt}, 64'd1);

      // No hazard: unused rs1 (lui x5) and a load to x0
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, OP_LOAD, 5'd5, 1'b1, OP_LUI, 5'd5, 5'd5);
      settle();
      checkOutput("lit.lui_nostall", {63'd0, aPcStall}, 64'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 64'd0, OP_LOAD, 5'd0, 1'b1, OP_R, 5'd0, 5'd0);
      settle();
      checkOutput("lit.x0_nostall", {63'd0, aPcStall}, 64'd0);
      checkOutput("lit.x0_lucnt", {32'd0, aLuCnt}, 64'd1);

      // Redirect, then one shadow cycle on A
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0040, OP_B, 5'd0, 1'b0, OP_IMM, 5'd0, 5'd0);
      settle();
      checkOutput("lit.redir_ctl", {56'd0, aCtl}, 64'h54);
      checkOutput("lit.redir_addr", aAddr, 64'h8000_0040);
      idle(1);
      settle();
      checkOutput("lit.shadow_ctl", {56'd0, aCtl}, 64'h10);
      checkOutput("lit.redir_cnt1", {32'd0, aRdCnt}, 64'd1);
      idle(1);
      settle();
      checkOutput("lit.back_run_ctl", {56'd0, aCtl}, 64'h00);
      idle(2);

      // Redirect together with a load-use hazard
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0100, OP_LOAD, 5'd7, 1'b1, OP_R, 5'd7, 5'd7);
      settle();
      checkOutput("lit.redir_lu_ctl", {56'd0, aCtl}, 64'h54);
      idle(3);
      settle();
      checkOutput("lit.redir_lu_lucnt", {32'd0, aLuCnt}, 64'd1);

      // Memory busy for 3 cycles over a pending redirect
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 64'h8000_0200, OP_JAL, 5'd1, 1'b1, OP_IMM, 5'd0, 5'd0);
         settle();
         checkOutput("lit.busy_ctl", {56'd0, aCtl}, 64'hAB);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h8000_0200, OP_JAL, 5'd1, 1'b1, OP_IMM, 5'd0, 5'd0);
      settle();
      checkOutput("lit.busy_drop_ctl", {56'd0, aCtl}, 64'h54);
      idle(3);
      settle();
      checkOutput("lit.busy_rdcnt", {32'd0, aRdCnt}, 64'd3);

      // Reset in the middle of SHADOW
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h40, OP_JAL, 5'd1, 1'b1, OP_IMM, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 64'd0, OP_IMM, 5'd0, 1'b0, OP_IMM, 5'd0, 5'd0);
      idle(1);
      settle();
      checkOutput("lit.rst_mid_shadow_B_ctl", {56'd0, bCtl}, 64'h00);
      checkOutput("lit.rst_rdcnt", {32'd0, aRdCnt}, 64'd0);

      // 16 back-to-back redirects wrap the 4-bit counter on B
      for (int i = 0; i < 16; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 64'(i * 4), OP_B, 5'd0, 1'b0, OP_IMM, 5'd0, 5'd0);
      end
      idle(1);
      settle();
      checkOutput("lit.wrap_B_rdcnt", {60'd0, bRdCnt}, 64'd0);
      checkOutput("lit.wrap_A_rdcnt", {32'd0, aRdCnt}, 64'd16);

      // Randomized traffic with small register ranges to provoke matches
      for (int i = 0; i < 1500; i++) begin
         logic [6:0] eop;
         eop = ($urandom_range(0, 2) != 0) ? OP_LOAD : idOps[$urandom_range(0, 9)];
         applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 5) == 0, {$urandom, $urandom}, eop,
                       5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                       idOps[$urandom_range(0, 9)], 5'($urandom_range(0, 3)),
                       5'($urandom_range(0, 3)));
      end
      settle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Detects load-use hazards that ID-stage forwarding cannot resolve and inserts the stall/bubble.
- Sequences flushes after a taken branch/jump redirect from EX.
- Freezes the whole pipe while data memory is busy, and keeps hazard/flush performance counters.

Parameters:
- SHADOW_CYCLES, 1, extra cycles IF/ID stays flushed after a redirect, covering the synchronous IRAM fetch latency; legal range 0..3.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; synchronous, active-high.
- id_opcode_i  in  7  opcode of the instruction in ID.
- id_rs1_addr_i  in  5  rs1 address in ID.
- id_rs2_addr_i  in  5  rs2 address in ID.
- ex_opcode_i  in  7  opcode of the instruction in EX.
- ex_rd_addr_i  in  5  rd address in EX.
- ex_wreg_i  in  1  EX instruction writes rd.
- ex_redirect_i  in  1  EX resolved a taken branch, jal or jalr.
- ex_redirect_pc_i  in  64  redirect target.
- mem_busy_i  in  1  data memory not ready this cycle.
- pc_stall_o  out  1  hold PC.
- pc_redirect_o  out  1  load PC from pc_redirect_addr_o.
- pc_redirect_addr_o  out  64  redirect target, passed through.
- if_id_stall_o  out  1  hold the IF/ID register.
- if_id_flush_o  out  1  load a bubble into IF/ID.
- id_ex_stall_o  out  1  hold the ID/EX register.
- id_ex_bubble_o  out  1  load a bubble into ID/EX.
- ex_mem_stall_o  out  1  hold the EX/MEM register.
- mem_wb_bubble_o  out  1  load a bubble into MEM/WB.
- loaduse_cnt_o  out  CNT_W  count of load-use stall cycles.
- redirect_cnt_o  out  CNT_W  count of redirects taken.

Behaviour:
- Register-usage decode from id_opcode_i:
  - rs1 is used by all opcodes except LUI, AUIPC and JAL.
  - rs2 is used only by R-type (0110011, 0111011), S-type and B-type.
- Load-use hazard (lu) = ex_opcode_i==0000011 && ex_wreg_i && ex_rd_addr_i!=0 && ((rs1 used && rs1 match) || (rs2 used && rs2 match)).
- FSM states: RUN, SHADOW (holds a down-counter sh_cnt, 2 bits).
- Priority, highest first. The outputs are combinational from state and inputs.
  1. rst: if_id_flush_o=1, id_ex_bubble_o=1, mem_wb_bubble_o=0; all other outputs 0. Next cycle: state RUN, counters 0, sh_cnt 0.
  2. mem_busy_i: pc_stall_o, if_id_stall_o, id_ex_stall_o and ex_mem_stall_o all =1; mem_wb_bubble_o=1.
     - Redirect, lu and SHADOW countdown are all suppressed. EX is held, so ex_redirect_i persists and is acted on after busy drops.
     - State and counters hold.
  3. ex_redirect_i: pc_redirect_o=1, if_id_flush_o=1, id_ex_bubble_o=1.
     - lu is ignored because the ID instruction is killed.
     - redirect_cnt +1.
     - If SHADOW_CYCLES>0: state goes to SHADOW with sh_cnt=SHADOW_CYCLES. A redirect arriving while already in SHADOW reloads sh_cnt.
  4. SHADOW: if_id_flush_o=1 and sh_cnt decrements. When sh_cnt reaches 1, state returns to RUN. lu is not evaluated, because the ID content is a bubble.
  5. lu (in RUN): pc_stall_o=1, if_id_stall_o=1, id_ex_bubble_o=1; loaduse_cnt +1.
     - The stall lasts exactly 1 cycle: EX then holds a bubble with wreg=0, and the load result is forwarded from MEM.
  6. Otherwise all control outputs are 0.
- Counters wrap modulo 2^CNT_W. They are cleared only by rst.
- pc_redirect_addr_o = ex_redirect_pc_i at all times; it is only meaningful when pc_redirect_o=1.
- Never asserted simultaneously on the same register: stall and flush/bubble. Stall wins only in the mem_busy case; that case never drives if_id_flush_o.

Decomposition:
- Shared defines header: opcode constants (load 0000011, R 0110011/0111011, S, B, LUI, AUIPC, JAL, JALR), the reg_zero constant, RegAddrBus, AddrBus, OpcodeBus.
- Register-usage decode as a sub-module: rs_use_decode (opcode -> rs1_used, rs2_used), reusable by the forwarding logic.
- FSM and counters stay in this module.

Test Plan:
- Load-use hazard. Stimulus: EX ld x5 (ex_opcode=0000011, rd=5, wreg=1); ID add x6,x5,x1. Required: one cycle with pc_stall=1, if_id_stall=1, id_ex_bubble=1; next cycle all 0; loaduse_cnt=1.
- No hazard from unused register or x0. Stimulus: EX ld x5 with ID lui x5 (rs1 not used); EX ld x0 with ID add x6,x0,x0. Required: no stall, counter unchanged.
- Redirect with SHADOW_CYCLES=1. Stimulus: ex_redirect=1, target 0x8000_0040. Required: pc_redirect=1, addr 0x8000_0040, if_id_flush=1, id_ex_bubble=1; next cycle if_id_flush=1 only; then RUN; redirect_cnt=1.
- Redirect during a load-use hazard. Stimulus: ex_redirect=1 and lu both true. Required: no pc_stall; redirect behaviour as above; loaduse_cnt unchanged.
- Memory busy over a redirect. Stimulus: mem_busy=1 for 3 cycles while ex_redirect=1. Required: full freeze outputs for 3 cycles with pc_redirect=0; redirect taken in the cycle mem_busy drops; redirect_cnt +1 only once.
- Reset mid-SHADOW, then counter wrap. Stimulus: assert rst during SHADOW; then force CNT_W=4 and run 16 redirects. Required: reset gives state RUN and counters 0; after 16 redirects redirect_cnt wraps to 0.
